// File: rtl/fetch_pkg.sv
// Shared fetch-packet types and default widths for the fetch/decode boundary.
package fetch_pkg;

    localparam int unsigned FETCH_W_DEFAULT = 3;
    localparam int unsigned PC_W_DEFAULT    = 32;
    localparam int unsigned INST_W_DEFAULT  = 32;

    typedef struct packed {
        logic [PC_W_DEFAULT-1:0]   pc;
        logic [INST_W_DEFAULT-1:0] inst;
        logic                      valid;
    } fetch_lane_t;

    typedef fetch_lane_t [FETCH_W_DEFAULT-1:0] fetch_packet_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetch packets between fetch and decode, with flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned FETCH_W = FETCH_W_DEFAULT,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_W    = PC_W_DEFAULT,
    parameter int unsigned INST_W  = INST_W_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_fq,
    input  logic                              enq_valid,
    output logic                              enq_ready,
    input  logic [FETCH_W-1:0][PC_W-1:0]      enq_pc,
    input  logic [FETCH_W-1:0][INST_W-1:0]    enq_inst,
    input  logic [FETCH_W-1:0]                enq_mask,
    output logic                              deq_valid,
    input  logic                              deq_ready,
    output logic [FETCH_W-1:0][PC_W-1:0]      deq_pc,
    output logic [FETCH_W-1:0][INST_W-1:0]    deq_inst,
    output logic [FETCH_W-1:0]                deq_mask,
    output logic [$clog2(DEPTH):0]            count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // Same layout as fetch_packet_t, resized by this instance's parameters.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              valid;
    } lane_t;

    typedef lane_t [FETCH_W-1:0] packet_t;

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    packet_t         mem_q [DEPTH];
    packet_t         mem_d [DEPTH];
    packet_t         enq_pkt;
    packet_t         head_pkt;
    logic            enq_fire;
    logic            enq_write;
    logic            deq_fire;

    // Ready/valid derive from registered occupancy only, so no ready path crosses the queue.
    assign enq_ready = count_q < CntW'(DEPTH);
    assign deq_valid = count_q != '0;
    assign count     = count_q;
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid & deq_ready;
    // An all-bubble packet completes the handshake but is never stored.
    assign enq_write = enq_fire & (|enq_mask);

    // Gather the per-lane inputs into one packet entry.
    always_comb begin
        enq_pkt = '0;
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            enq_pkt[i].pc    = enq_pc[i];
            enq_pkt[i].inst  = enq_inst[i];
            enq_pkt[i].valid = enq_mask[i];
        end
    end

    // Pointer, occupancy and storage next-state; flush overrides any fire this cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush_fq) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_write) begin
                mem_d[tail_q] = enq_pkt;
                tail_d        = tail_q + PtrW'(1);
            end
            if (deq_fire) begin
                head_d = head_q + PtrW'(1);
            end
            if (enq_write && !deq_fire) begin
                count_d = count_q + CntW'(1);
            end else if (!enq_write && deq_fire) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    // Present the head entry, zeroed whenever the queue is empty.
    always_comb begin
        head_pkt = deq_valid ? mem_q[head_q] : '0;
        deq_pc   = '0;
        deq_inst = '0;
        deq_mask = '0;
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            deq_pc[i]   = head_pkt[i].pc;
            deq_inst[i] = head_pkt[i].inst;
            deq_mask[i] = head_pkt[i].valid;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue against a queue-based packet model.
module tb_fetch_queue;

    localparam int FW = 3;
    localparam int D  = 4;
    localparam int PW = 32;
    localparam int IW = 32;

    typedef logic [FW-1:0][PW-1:0] pcv_t;
    typedef logic [FW-1:0][IW-1:0] instv_t;

    typedef struct {
        pcv_t           pc;
        instv_t         inst;
        logic [FW-1:0]  mask;
    } pkt_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           flush_fq = 1'b0;
    logic           enq_valid = 1'b0;
    logic           deq_ready = 1'b0;
    pcv_t           enq_pc = '0;
    instv_t         enq_inst = '0;
    logic [FW-1:0]  enq_mask = '0;
    logic           enq_ready;
    logic           deq_valid;
    pcv_t           deq_pc;
    instv_t         deq_inst;
    logic [FW-1:0]  deq_mask;
    logic [2:0]     count;

    pkt_t mq[$];
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .FETCH_W (FW),
        .DEPTH   (D),
        .PC_W    (PW),
        .INST_W  (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_fq  (flush_fq),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_pc    (enq_pc),
        .enq_inst  (enq_inst),
        .enq_mask  (enq_mask),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_pc    (deq_pc),
        .deq_inst  (deq_inst),
        .deq_mask  (deq_mask),
        .count     (count)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic pcv_t mkpc(input logic [31:0] b);
        pcv_t r;
        for (int i = 0; i < FW; i++) r[i] = b + 32'(4 * i);
        return r;
    endfunction

    function automatic instv_t mkinst(input pcv_t p);
        instv_t r;
        for (int i = 0; i < FW; i++) r[i] = p[i] ^ 32'h1357_9bdf;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] b, input logic [FW-1:0] m);
        enq_valid = v;
        enq_pc    = mkpc(b);
        enq_inst  = mkinst(enq_pc);
        enq_mask  = m;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference model: FIFO of stored packets, updated from the handshake rules.
    always @(posedge clk or negedge rst) begin
        bit ef;
        bit df;
        if (!rst) begin
            mq.delete();
        end else if (flush_fq) begin
            mq.delete();
        end else begin
            ef = enq_valid && (mq.size() < D);
            df = deq_ready && (mq.size() > 0);
            if (df) void'(mq.pop_front());
            if (ef && enq_mask != '0) mq.push_back('{enq_pc, enq_inst, enq_mask});
        end
    end

    // Every cycle out of reset, outputs must match the model's view.
    always @(negedge clk) begin
        pkt_t h;
        if (rst) begin
            h.pc   = '0;
            h.inst = '0;
            h.mask = '0;
            if (mq.size() > 0) h = mq[0];
            chk("model_count", count, mq.size());
            chk("model_enq_ready", enq_ready, mq.size() < D);
            chk("model_deq_valid", deq_valid, mq.size() != 0);
            chk("model_deq_pc", deq_pc, h.pc);
            chk("model_deq_inst", deq_inst, h.inst);
            chk("model_deq_mask", deq_mask, h.mask);
        end
    end

    initial begin
        // Reset state while rst is held low.
        #12;
        chk("rst_count", count, 0);
        chk("rst_enq_ready", enq_ready, 1);
        chk("rst_deq_valid", deq_valid, 0);
        chk("rst_deq_pc", deq_pc, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Single packet, one-cycle latency.
        drive(1'b1, 32'h1c00_0000, 3'b111);
        deq_ready = 1'b0;
        step();
        drive(1'b0, 32'h0, 3'b000);
        chk("first_deq_valid", deq_valid, 1);
        chk("first_deq_pc", deq_pc, 96'h1c000008_1c000004_1c000000);
        chk("first_count", count, 1);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        chk("first_drain_count", count, 0);

        // Fill to full, extra enq ignored, drain in order.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h100 + 32'(k * 'h40), (k == 2) ? 3'b011 : 3'b111);
            step();
        end
        chk("full_count", count, 4);
        chk("full_enq_ready", enq_ready, 0);
        drive(1'b1, 32'h900, 3'b111);
        step();
        drive(1'b0, 32'h0, 3'b000);
        chk("full_ignore_count", count, 4);
        deq_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("full_order_pc", deq_pc[0], 32'h100 + 32'(k * 'h40));
            if (k == 2) chk("full_order_mask", deq_mask, 3'b011);
            step();
        end
        deq_ready = 1'b0;
        chk("full_drain_count", count, 0);
        chk("full_drain_valid", deq_valid, 0);

        // Bubble packet is accepted but not stored.
        drive(1'b1, 32'h500, 3'b000);
        chk("bubble_enq_ready", enq_ready, 1);
        step();
        drive(1'b0, 32'h0, 3'b000);
        chk("bubble_count", count, 0);
        chk("bubble_deq_valid", deq_valid, 0);

        // Full with simultaneous deq: enq refused that cycle, accepted next.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h600 + 32'(k * 'h40), 3'b111);
            step();
        end
        drive(1'b1, 32'h700, 3'b111);
        deq_ready = 1'b1;
        step();
        chk("fulldeq_count", count, 3);
        chk("fulldeq_enq_ready", enq_ready, 1);
        chk("fulldeq_head", deq_pc[0], 32'h640);
        deq_ready = 1'b0;
        step();
        drive(1'b0, 32'h0, 3'b000);
        chk("refill_count", count, 4);
        deq_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("refill_order_pc", deq_pc[0], 32'h640 + 32'(k * 'h40));
            step();
        end

        // Continuous streaming across pointer wrap.
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h2000 + 32'(k * 'h10), 3'b111);
            step();
            chk("wrap_pc", deq_pc[0], 32'h2000 + 32'(k * 'h10));
            chk("wrap_count", count, 1);
        end
        drive(1'b0, 32'h0, 3'b000);
        step();
        deq_ready = 1'b0;
        chk("wrap_drain_count", count, 0);

        // Flush beats a concurrent enq and deq.
        drive(1'b1, 32'h3000, 3'b111);
        step();
        drive(1'b1, 32'h3040, 3'b111);
        step();
        chk("preflush_count", count, 2);
        flush_fq = 1'b1;
        drive(1'b1, 32'h3080, 3'b111);
        deq_ready = 1'b1;
        step();
        flush_fq = 1'b0;
        drive(1'b0, 32'h0, 3'b000);
        deq_ready = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_deq_valid", deq_valid, 0);
        drive(1'b1, 32'h4000, 3'b101);
        step();
        drive(1'b0, 32'h0, 3'b000);
        chk("postflush_pc", deq_pc[0], 32'h4000);
        chk("postflush_mask", deq_mask, 3'b101);
        chk("postflush_count", count, 1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised fetch-packet buffer between the PC/fetch stage and decode.
- Replaces the single-entry IF pipeline register with a DEPTH-entry FIFO of FETCH_W-wide packets.
- Each lane carries its own valid bit.
- Uses a ready/valid handshake on both sides, so back-pressure from decode no longer freezes fetch immediately.
- A flush drops every buffered packet after a branch redirect or exception.

Parameters:
- FETCH_W, 3, instruction lanes per fetch packet (>=1)
- DEPTH, 4, packet entries; power of two, >=2
- PC_W, 32, PC width per lane
- INST_W, 32, instruction word width per lane

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush_fq  in  1  synchronous flush; empties the queue
- enq_valid  in  1  fetch presents a packet
- enq_ready  out  1  queue can accept a packet
- enq_pc  in  FETCH_W x PC_W  per-lane PC
- enq_inst  in  FETCH_W x INST_W  per-lane instruction
- enq_mask  in  FETCH_W  per-lane valid
- deq_valid  out  1  head packet available
- deq_ready  in  1  decode consumes the head packet
- deq_pc  out  FETCH_W x PC_W  head per-lane PC
- deq_inst  out  FETCH_W x INST_W  head per-lane instruction
- deq_mask  out  FETCH_W  head per-lane valid
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst low, async): head/tail pointers=0, count=0, all storage=0. enq_ready=1, deq_valid=0, deq_pc/deq_inst/deq_mask=0.
- enq fire = enq_valid & enq_ready. deq fire = deq_valid & deq_ready.
- enq_ready = (count < DEPTH). It is registered-state only and never depends on deq_ready (no combinational ready path).
- deq_valid = (count != 0).
- deq_* are driven from the head entry. When empty they are forced to all zero.
- Enq fire with enq_mask==0: the handshake completes but nothing is written. Tail and count are unchanged (bubble packets are squashed).
- Enq fire with enq_mask!=0: the packet is written at tail and tail advances by 1.
- Deq fire: head advances by 1.
- count update: +1 on a written enq only, -1 on deq only, unchanged on both or neither.
- Latency: a packet enqueued in cycle N is visible on deq_* in cycle N+1. There is no same-cycle enq-to-deq bypass.
- Full (count==DEPTH): enq_ready=0, so enq_valid is ignored. A deq in that cycle frees a slot, and enq_ready rises the next cycle.
- Empty with enq fire: deq_valid stays 0 this cycle; the packet appears next cycle.
- Simultaneous enq+deq, non-empty and non-full: both happen and count is unchanged.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count distinguishes full from empty.
- flush_fq=1 has priority over everything:
  - next cycle head=tail=0, count=0, deq_valid=0;
  - any enq or deq fire in the flush cycle is discarded;
  - storage contents need not be cleared.
- Stall semantics come only from deq_ready=0: the head entry holds stable, as do deq_* and count.

Decomposition:
- Package fetch_pkg holds:
  - FETCH_W default constant;
  - typedef fetch_lane_t {pc, inst, valid};
  - typedef fetch_packet_t = FETCH_W x fetch_lane_t.
- The queue stores fetch_packet_t entries.
- No sub-module is required. Pointer/count logic stays inline; the storage array is plain registers (DEPTH is small).

Test Plan:
- Reset then idle -> count=0, enq_ready=1, deq_valid=0, deq_pc all 0.
- Enq pc {0x1c000000,0x1c000004,0x1c000008}, mask 3'b111, deq_ready=0 -> next cycle deq_valid=1, deq_pc matches, count=1.
- Enq 4 packets with deq_ready=0 -> count=4, enq_ready=0. A 5th enq_valid is ignored. Then deq_ready=1 for 4 cycles -> packets emerge in order and count returns to 0.
- Enq mask 3'b000 while empty -> enq handshake completes, count stays 0, deq_valid stays 0.
- Full queue, deq fire same cycle enq_valid=1 -> enq not accepted, count=3. Next cycle enq_ready=1 and enq accepted -> count=4. Wrap verified with 10 continuous enq/deq packets in order.
- count=2, flush_fq=1 with enq fire and deq_ready=1 -> next cycle count=0, deq_valid=0; the following enq appears at head correctly.
